// File: rtl/gain_pkg.sv
// Shared widths, sample types and clip limits for the gain/effect datapath.
package gain_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 12;
  localparam int OUT_W  = 32;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [DATA_W-1:0] gain_t;
  typedef logic signed [OUT_W-1:0]  wide_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/gain_q12_sat_clip.sv
// Combinational signed clipper: folds a wide two's-complement value into
// OUT_W bits, flagging when the value had to be clamped.
module sat_clip
  import gain_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_x,
  output logic [OUT_W-1:0] o_y,
  output logic             o_ovf
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] w_x;

  assign w_x = $signed(i_x);

  always_comb begin
    o_y   = i_x[OUT_W-1:0];
    o_ovf = 1'b0;
    if (w_x > MAX_V) begin
      o_y   = {1'b0, {(OUT_W-1){1'b1}}};
      o_ovf = 1'b1;
    end else if (w_x < MIN_V) begin
      o_y   = {1'b1, {(OUT_W-1){1'b0}}};
      o_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/gain_q12.sv
// Two-stage signed Q4.12 gain: sample * gain, floor-scaled by 2^FRAC_W,
// returned full-width and clipped to the sample range.
module gain_q12
  import gain_pkg::*;
#(
  parameter int DATA_W = gain_pkg::DATA_W,
  parameter int FRAC_W = gain_pkg::FRAC_W,
  parameter int OUT_W  = gain_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [OUT_W-1:0]  y,
  output logic [DATA_W-1:0] y_sat,
  output logic              ovf
);

  logic signed [DATA_W-1:0]   r_a_p1;
  logic signed [DATA_W-1:0]   r_b_p1;
  logic                       r_vld_p1;

  logic signed [2*DATA_W-1:0] w_prod_p1;
  logic signed [OUT_W-1:0]    w_y_p1;
  logic [DATA_W-1:0]          w_sat_p1;
  logic                       w_ovf_p1;

  logic signed [OUT_W-1:0]    r_y_p2;
  logic [DATA_W-1:0]          r_sat_p2;
  logic                       r_ovf_p2;
  logic                       r_vld_p2;

  // Arithmetic shift on the exact product rounds toward -inf.
  function automatic logic signed [OUT_W-1:0] scale_floor(input logic signed [2*DATA_W-1:0] p);
    logic signed [2*DATA_W-1:0] s;
    s = p >>> FRAC_W;
    return OUT_W'(s);
  endfunction

  // Stage 1: capture operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_a_p1   <= '0;
      r_b_p1   <= '0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_a_p1 <= $signed(a);
        r_b_p1 <= $signed(b);
      end
    end
  end

  assign w_prod_p1 = r_a_p1 * r_b_p1;
  assign w_y_p1    = scale_floor(w_prod_p1);

  sat_clip #(
    .IN_W  (OUT_W),
    .OUT_W (DATA_W)
  ) u_sat_clip (
    .i_x   (w_y_p1),
    .o_y   (w_sat_p1),
    .o_ovf (w_ovf_p1)
  );

  // Stage 2: multiply, scale, clip
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2 <= 1'b0;
      r_y_p2   <= '0;
      r_sat_p2 <= '0;
      r_ovf_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_y_p2   <= w_y_p1;
        r_sat_p2 <= w_sat_p1;
        r_ovf_p2 <= w_ovf_p1;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign y         = r_y_p2;
  assign y_sat     = r_sat_p2;
  assign ovf       = r_ovf_p2;

endmodule

// File: tb/tb_gain_q12.sv
// Directed-vector bench for gain_q12 with an in-order expected-result queue.
module tb_gain_q12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [31:0] y;
  logic [15:0] y_sat;
  logic        ovf;

  typedef struct {
    int     launch;
    longint ey;
    longint es;
    longint eo;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  longint last_y = 0;
  longint last_s = 0;
  longint last_o = 0;

  gain_q12 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y         (y),
    .y_sat     (y_sat),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Floor division done by integer arithmetic, independent of shifting.
  task automatic model(input int av, input int bv, output longint yy, output longint ys, output longint ov);
    longint p;
    p = longint'(av) * longint'(bv);
    if (p >= 0) yy = p / 4096;
    else        yy = -((-p + 4095) / 4096);
    if (yy > 32767) begin
      ys = 32767;  ov = 1;
    end else if (yy < -32768) begin
      ys = -32768; ov = 1;
    end else begin
      ys = yy;     ov = 0;
    end
  endtask

  task automatic step(input bit rv, input bit v, input int av, input int bv,
                      input longint ey, input longint es, input longint eo);
    bit   exp_v;
    exp_t e;
    @(negedge clk);
    cyc++;
    exp_v = (q.size() > 0) && (q[0].launch + 2 == cyc);
    chk("out_valid", out_valid, exp_v);
    if (exp_v) begin
      e = q.pop_front();
      chk("y", $signed(y), e.ey);
      chk("y_sat", $signed(y_sat), e.es);
      chk("ovf", ovf, e.eo);
      last_y = e.ey;
      last_s = e.es;
      last_o = e.eo;
    end else begin
      chk("hold_y", $signed(y), last_y);
      chk("hold_y_sat", $signed(y_sat), last_s);
      chk("hold_ovf", ovf, last_o);
    end
    rst_n    = rv;
    in_valid = v;
    a        = av[15:0];
    b        = bv[15:0];
    if (!rv) begin
      q.delete();
      last_y = 0;
      last_s = 0;
      last_o = 0;
    end else if (v) begin
      q.push_back('{cyc, ey, es, eo});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 12345, -777, 0, 0, 0);
  endtask

  initial begin
    longint my, ms, mo;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);

    // Reset state, with in_valid asserted but ignored
    step(1'b0, 1'b1, 1000, 4096, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    idle(3);

    // Directed vectors, back-to-back
    step(1'b1, 1'b1,   1000,   4096,    1000,   1000, 0);
    step(1'b1, 1'b1,  -4096,   1000,   -1000,  -1000, 0);
    step(1'b1, 1'b1,      3,     -1,      -1,     -1, 0);
    step(1'b1, 1'b1,      3,      1,       0,      0, 0);
    step(1'b1, 1'b1,     -1,      1,      -1,     -1, 0);
    step(1'b1, 1'b1,      7,   2048,       3,      3, 0);
    step(1'b1, 1'b1,     -7,   2048,      -4,     -4, 0);
    step(1'b1, 1'b1,   8192,  20000,   40000,  32767, 1);
    step(1'b1, 1'b1, -32768,  32767, -262136, -32768, 1);
    step(1'b1, 1'b1, -32768, -32768,  262144,  32767, 1);
    step(1'b1, 1'b1,  32767,   4096,   32767,  32767, 0);
    step(1'b1, 1'b1, -32768,   4096,  -32768, -32768, 0);
    step(1'b1, 1'b1,  16384,   8192,   32768,  32767, 1);
    step(1'b1, 1'b1,  -8193,  16384,  -32772, -32768, 1);
    step(1'b1, 1'b1,  32767,   4097,   32774,  32767, 1);
    idle(3);

    // Gapped stream 1,0,1,1,0
    step(1'b1, 1'b1,  100,  4096, 100, 100, 0);
    step(1'b1, 1'b0,  12345, -777,  0,   0, 0);
    step(1'b1, 1'b1,   -5, -8192,  10,  10, 0);
    step(1'b1, 1'b1,    9,  2048,   4,   4, 0);
    step(1'b1, 1'b0,  -321,   55,   0,   0, 0);
    idle(3);

    // Mid-stream reset: one pair in stage 1, one presented during reset
    step(1'b1, 1'b1, 500, 8192, 1000, 1000, 0);
    step(1'b1, 1'b1, 700, 4096,  700,  700, 0);
    step(1'b0, 1'b1,   9,    9,    0,    0, 0);
    idle(2);
    step(1'b1, 1'b1, -100, 4096, -100, -100, 0);
    idle(3);

    // Strided sweep, back-to-back; b stride offset by a so all residues appear
    for (int i = 0; i < 512; i++) begin
      for (int j = 0; j < 64; j++) begin
        int av, bv;
        av = -32768 + 128 * i;
        bv = -32768 + 1024 * j + 128 * (i % 8);
        model(av, bv, my, ms, mo);
        step(1'b1, 1'b1, av, bv, my, ms, mo);
      end
    end
    idle(4);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
